alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one ALU_32bit instance between two requesters (e.g. execute stage and address/branch unit).
//  Round-robin arbitration, valid/ready handshakes on both request and response sides.
//  Operands and ALU outputs are registered; one transaction in flight at a time.
// PARAMETERS
//  WIDTH   32  operand/result width
//  OP_W    4   ALU OpCode width
//  FLAG_W  4   response flag bundle {SLTFlag,OverflowFlag,ZeroFlag,Cout}
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       synchronous, active-high reset
//  rN_req_valid   in   1       requester N (N=0,1) has an operation
//  rN_req_ready   out  1       arbiter accepts requester N this cycle
//  rN_A, rN_B     in   WIDTH   operands
//  rN_OpCode      in   OP_W    ALU operation
//  rN_rsp_valid   out  1       result for requester N is valid
//  rN_rsp_ready   in   1       requester N consumes the result
//  rsp_Result     out  WIDTH   shared registered result
//  rsp_Flags      out  FLAG_W  shared registered flags
//  alu_A, alu_B   out  WIDTH   to ALU operand inputs
//  alu_OpCode     out  OP_W    to ALU OpCode
//  alu_Result     in   WIDTH   from ALU
//  alu_Cout, alu_ZeroFlag, alu_OverflowFlag, alu_SLTFlag  in  1  from ALU
// BEHAVIOUR
//  FSM: IDLE -> EXEC -> RESP -> IDLE. Reset: IDLE, all ready/valid 0, rsp_Result/rsp_Flags 0,
//   alu_A/alu_B/alu_OpCode 0, last_grant=1 (r0 wins first tie).
//  IDLE: rN_req_ready combinational = (winner==N); at most one ready high per cycle.
//   Winner: if only one valid, it; if both, the one != last_grant. Handshake on valid&ready edge:
//   latch A,B,OpCode into alu_* regs, record owner, last_grant<=owner, -> EXEC.
//  EXEC (1 cycle): ALU sees registered operands; at edge capture alu_Result and
//   {SLT,Ovf,Zero,Cout} into rsp_Result/rsp_Flags, -> RESP. Both req_ready 0.
//  RESP: r<owner>_rsp_valid=1, other rsp_valid=0; held, with rsp_Result/rsp_Flags stable,
//   until r<owner>_rsp_ready=1, then -> IDLE. Both req_ready 0 while in RESP.
//  Latency: accept at edge k; rsp_valid high from cycle after edge k+1; min 3 cycles/op.
//  Requests during EXEC/RESP are stalled (ready 0), not dropped; requester holds payload.
//  Requester may deassert valid before handshake; no state change.
//  alu_* and rsp_* hold last values in IDLE (no zeroing between ops).
//  rsp_ready while rsp_valid=0 is ignored.
//  Reset mid-operation (EXEC or RESP): transaction abandoned, no response issued, all reset values.
//  Arithmetic fully delegated to ALU; no width conversion; flags passed unmodified.
// TESTING
//  1 Reset, r0 only: A=5,B=3,OpCode=ADD -> r0_rsp_valid 2 cycles after accept, Result=8, Flags=0000.
//  2 Both valid after reset, back-to-back: r0 served first, then r1; next tie -> r0 again (alternation).
//  3 r1 SUB A=7,B=7 -> Result=0, ZeroFlag bit=1; hold r1_rsp_ready=0 5 cycles -> rsp stable, r0/r1 ready 0.
//  4 A=32'h7FFFFFFF,B=1,ADD -> Result=32'h80000000, OverflowFlag=1; Cout=0.
//  5 Assert rst during EXEC -> next cycle all valid/ready 0, no rsp_valid ever for that op, r0 wins next tie.
//  6 48 random ops both ports, random rsp_ready stalls -> each result matches ALU model, in order per port, none lost/duplicated.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one external 32-bit ALU between two requesters.
// Round-robin grant, valid/ready on both request and response sides, one
// transaction in flight. Operands and ALU results are registered, so an op
// occupies IDLE(accept) -> EXEC -> RESP, three cycles minimum.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int OP_W   = 4,
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,

  // requester 0
  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic [WIDTH-1:0]  r0_A,
  input  logic [WIDTH-1:0]  r0_B,
  input  logic [OP_W-1:0]   r0_OpCode,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,

  // requester 1
  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic [WIDTH-1:0]  r1_A,
  input  logic [WIDTH-1:0]  r1_B,
  input  logic [OP_W-1:0]   r1_OpCode,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,

  // shared response payload
  output logic [WIDTH-1:0]  rsp_Result,
  output logic [FLAG_W-1:0] rsp_Flags,

  // ALU side
  output logic [WIDTH-1:0]  alu_A,
  output logic [WIDTH-1:0]  alu_B,
  output logic [OP_W-1:0]   alu_OpCode,
  input  logic [WIDTH-1:0]  alu_Result,
  input  logic              alu_Cout,
  input  logic              alu_ZeroFlag,
  input  logic              alu_OverflowFlag,
  input  logic              alu_SLTFlag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q;
  logic               owner_q;       // requester index of the op in flight
  logic               last_grant_q;  // requester index granted most recently
  logic [WIDTH-1:0]   alu_a_q;
  logic [WIDTH-1:0]   alu_b_q;
  logic [OP_W-1:0]    alu_op_q;
  logic [WIDTH-1:0]   result_q;
  logic [FLAG_W-1:0]  flags_q;
  logic               rsp_valid0_q;
  logic               rsp_valid1_q;

  logic               grant0;
  logic               grant1;
  logic               rsp_done;

  // Round-robin winner; only offered while IDLE so at most one ready is high.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (r0_req_valid && r1_req_valid) begin
        // tie: favour the requester that was not granted last
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = r0_req_valid;
        grant1 = r1_req_valid;
      end
    end
  end

  // Response handshake by the owning requester only; other rsp_ready is ignored.
  always_comb begin
    rsp_done = 1'b0;
    if (state_q == RESP) begin
      rsp_done = owner_q ? r1_rsp_ready : r0_rsp_ready;
    end
  end

  // Transaction FSM with registered operands, results and response valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      result_q     <= '0;
      flags_q      <= '0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            alu_a_q      <= grant1 ? r1_A      : r0_A;
            alu_b_q      <= grant1 ? r1_B      : r0_B;
            alu_op_q     <= grant1 ? r1_OpCode : r0_OpCode;
            owner_q      <= grant1;
            last_grant_q <= grant1;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          result_q     <= alu_Result;
          flags_q      <= FLAG_W'({alu_SLTFlag, alu_OverflowFlag, alu_ZeroFlag, alu_Cout});
          rsp_valid0_q <= !owner_q;
          rsp_valid1_q <= owner_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign r0_req_ready = grant0;
  assign r1_req_ready = grant1;
  assign r0_rsp_valid = rsp_valid0_q;
  assign r1_rsp_valid = rsp_valid1_q;
  assign rsp_Result   = result_q;
  assign rsp_Flags    = flags_q;
  assign alu_A        = alu_a_q;
  assign alu_B        = alu_b_q;
  assign alu_OpCode   = alu_op_q;

endmodule
